// File: rtl/y_row_fetch_seq.sv
// Row-range sequencer: fetches per-row start/end pointers from the pointer SRAM and
// streams each row's Y-data addresses. Optional empty-row marker beat: YSEQ_EMPTY_ROW_MARK_EN.
module y_row_fetch_seq #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_row,
  input  logic [ADDR_W-1:0] end_row,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ptr_rd_en,
  output logic [ADDR_W-1:0] ptr_rd_addr,
  input  logic [DATA_W-1:0] ptr_rd_data,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [ADDR_W-1:0] y_addr,
  output logic [ADDR_W-1:0] y_row,
  output logic              y_last,
  output logic              y_empty
);

  localparam int SLOT_BITS = 16;
  localparam int SLOTS     = DATA_W / SLOT_BITS;
  localparam int SLOT_W    = $clog2(SLOTS);
  localparam int IDX_W     = ADDR_W - SLOT_W;
  localparam int PAD_W     = SLOT_BITS - ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PTR_REQ, ST_PTR_WAIT, ST_NXT_REQ, ST_NXT_WAIT, ST_STREAM, ST_ADV, ST_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [IDX_W-1:0]  widx_q, widx_d;
  logic [ADDR_W-1:0] p_lo_q, p_lo_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [ADDR_W-1:0] buf_q [SLOTS];
  logic [ADDR_W-1:0] buf_d [SLOTS];
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ptr_rd_en_q, ptr_rd_en_d;
  logic [ADDR_W-1:0] ptr_rd_addr_q, ptr_rd_addr_d;
  logic              y_valid_q, y_valid_d;
  logic [ADDR_W-1:0] y_addr_q, y_addr_d;
  logic              y_last_q, y_last_d;

  logic [ADDR_W-1:0]      rd_slot [SLOTS];
  logic [SLOTS*PAD_W-1:0] pad_bits;
  logic                   unused_pad;

  // Only the low ADDR_W bits of each 16-bit pointer slot carry an address.
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    assign rd_slot[gi]                 = ptr_rd_data[gi*SLOT_BITS +: ADDR_W];
    assign pad_bits[gi*PAD_W +: PAD_W] = ptr_rd_data[gi*SLOT_BITS+ADDR_W +: PAD_W];
  end
  assign unused_pad = ^pad_bits;

  logic [SLOT_W-1:0] cur_slot, cur_slot_p1;
  logic [ADDR_W-1:0] row_nxt;
  logic [SLOT_W-1:0] nxt_slot, nxt_slot_p1;

  assign cur_slot    = cur_q[SLOT_W-1:0];
  assign cur_slot_p1 = cur_slot + SLOT_W'(1);
  assign row_nxt     = cur_q + ADDR_W'(1);
  assign nxt_slot    = row_nxt[SLOT_W-1:0];
  assign nxt_slot_p1 = nxt_slot + SLOT_W'(1);

  logic              ent_go;
  logic [ADDR_W-1:0] ent_lo, ent_hi;

`ifdef YSEQ_EMPTY_ROW_MARK_EN
  logic y_empty_q, y_empty_d;
`endif

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    end_d         = end_q;
    widx_d        = widx_q;
    p_lo_d        = p_lo_q;
    last_addr_d   = last_addr_q;
    buf_d         = buf_q;
    done_d        = 1'b0;
    err_d         = err_q;
    ptr_rd_en_d   = 1'b0;
    ptr_rd_addr_d = ptr_rd_addr_q;
    y_valid_d     = y_valid_q;
    y_addr_d      = y_addr_q;
    y_last_d      = y_last_q;
`ifdef YSEQ_EMPTY_ROW_MARK_EN
    y_empty_d     = y_empty_q;
`endif
    ent_go        = 1'b0;
    ent_lo        = '0;
    ent_hi        = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          end_d = end_row;
          cur_d = start_row;
          err_d = 1'b0;
          if (end_row < start_row) begin
            state_d = ST_FIN;
          end else begin
            state_d       = ST_PTR_REQ;
            ptr_rd_en_d   = 1'b1;
            ptr_rd_addr_d = start_row >> SLOT_W;
          end
        end
      end
      ST_PTR_REQ: state_d = ST_PTR_WAIT;
      ST_PTR_WAIT: begin
        buf_d  = rd_slot;
        widx_d = ptr_rd_addr_q[IDX_W-1:0];
        if (&cur_slot) begin
          // End pointer lives in slot 0 of the following word.
          p_lo_d        = rd_slot[cur_slot];
          ptr_rd_en_d   = 1'b1;
          ptr_rd_addr_d = ptr_rd_addr_q + ADDR_W'(1);
          state_d       = ST_NXT_REQ;
        end else begin
          ent_go = 1'b1;
          ent_lo = rd_slot[cur_slot];
          ent_hi = rd_slot[cur_slot_p1];
        end
      end
      ST_NXT_REQ: state_d = ST_NXT_WAIT;
      ST_NXT_WAIT: begin
        buf_d  = rd_slot;
        widx_d = ptr_rd_addr_q[IDX_W-1:0];
        ent_go = 1'b1;
        ent_lo = p_lo_q;
        ent_hi = rd_slot[0];
      end
      ST_STREAM: begin
        if (y_valid_q && y_ready) begin
          if (y_last_q) begin
            y_valid_d = 1'b0;
            y_last_d  = 1'b0;
`ifdef YSEQ_EMPTY_ROW_MARK_EN
            y_empty_d = 1'b0;
`endif
            state_d   = ST_ADV;
          end else begin
            y_addr_d = y_addr_q + ADDR_W'(1);
            y_last_d = ((y_addr_q + ADDR_W'(1)) == last_addr_q);
          end
        end
      end
      ST_ADV: begin
        // Compare before incrementing so end_row at the top of the space never wraps.
        if (cur_q == end_q) begin
          state_d = ST_FIN;
        end else begin
          cur_d = row_nxt;
          if (row_nxt[ADDR_W-1:SLOT_W] == widx_q) begin
            if (&nxt_slot) begin
              p_lo_d        = buf_q[nxt_slot];
              ptr_rd_en_d   = 1'b1;
              ptr_rd_addr_d = (row_nxt >> SLOT_W) + ADDR_W'(1);
              state_d       = ST_NXT_REQ;
            end else begin
              ent_go = 1'b1;
              ent_lo = buf_q[nxt_slot];
              ent_hi = buf_q[nxt_slot_p1];
            end
          end else begin
            ptr_rd_en_d   = 1'b1;
            ptr_rd_addr_d = row_nxt >> SLOT_W;
            state_d       = ST_PTR_REQ;
          end
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Row entry: either open a stream of beats or handle a degenerate extent.
    if (ent_go) begin
      if (ent_hi <= ent_lo) begin
        if (ent_hi < ent_lo) err_d = 1'b1;
`ifdef YSEQ_EMPTY_ROW_MARK_EN
        state_d   = ST_STREAM;
        y_valid_d = 1'b1;
        y_addr_d  = ent_lo;
        y_last_d  = 1'b1;
        y_empty_d = 1'b1;
`else
        state_d   = ST_ADV;
`endif
      end else begin
        state_d     = ST_STREAM;
        y_valid_d   = 1'b1;
        y_addr_d    = ent_lo;
        last_addr_d = ent_hi - ADDR_W'(1);
        y_last_d    = (ent_lo == (ent_hi - ADDR_W'(1)));
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cur_q         <= '0;
      end_q         <= '0;
      widx_q        <= '0;
      p_lo_q        <= '0;
      last_addr_q   <= '0;
      for (int i = 0; i < SLOTS; i++) buf_q[i] <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      ptr_rd_en_q   <= 1'b0;
      ptr_rd_addr_q <= '0;
      y_valid_q     <= 1'b0;
      y_addr_q      <= '0;
      y_last_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      end_q         <= end_d;
      widx_q        <= widx_d;
      p_lo_q        <= p_lo_d;
      last_addr_q   <= last_addr_d;
      buf_q         <= buf_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      ptr_rd_en_q   <= ptr_rd_en_d;
      ptr_rd_addr_q <= ptr_rd_addr_d;
      y_valid_q     <= y_valid_d;
      y_addr_q      <= y_addr_d;
      y_last_q      <= y_last_d;
    end
  end

`ifdef YSEQ_EMPTY_ROW_MARK_EN
  always_ff @(posedge clock) begin
    if (!reset) y_empty_q <= 1'b0;
    else        y_empty_q <= y_empty_d;
  end
  assign y_empty = y_empty_q;
`else
  assign y_empty = 1'b0;
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign ptr_rd_en   = ptr_rd_en_q;
  assign ptr_rd_addr = ptr_rd_addr_q;
  assign y_valid     = y_valid_q;
  assign y_addr      = y_addr_q;
  assign y_row       = cur_q;
  assign y_last      = y_last_q;

endmodule

// File: tb/tb_y_row_fetch_seq.sv
// Bench for y_row_fetch_seq: directed cases plus random pointer tables and backpressure,
// checked against a flat row-pointer-table model. Honours YSEQ_EMPTY_ROW_MARK_EN.
module tb_y_row_fetch_seq;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 256;
  localparam int TAB_N  = 2064;
  localparam int BUDGET = 3000;

  logic              clock = 1'b0;
  logic              reset, start;
  logic [ADDR_W-1:0] start_row, end_row;
  logic              busy, done, err, ptr_rd_en;
  logic [ADDR_W-1:0] ptr_rd_addr;
  logic [DATA_W-1:0] ptr_rd_data;
  logic              y_valid, y_ready, y_last, y_empty;
  logic [ADDR_W-1:0] y_addr, y_row;

  always #5 clock = ~clock;

  y_row_fetch_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset), .start(start), .start_row(start_row), .end_row(end_row),
    .busy(busy), .done(done), .err(err), .ptr_rd_en(ptr_rd_en), .ptr_rd_addr(ptr_rd_addr),
    .ptr_rd_data(ptr_rd_data), .y_valid(y_valid), .y_ready(y_ready), .y_addr(y_addr),
    .y_row(y_row), .y_last(y_last), .y_empty(y_empty)
  );

  // Flat pointer table: row r spans [tab[r], tab[r+1]) in the low ADDR_W bits.
  logic [15:0] tab [TAB_N];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc, rdy_mode, done_cnt, first_rd, first_valid, done_cyc;
  logic              pend_v;
  logic [ADDR_W-1:0] pend_a;
  logic              exp_err;
  logic [2*ADDR_W+1:0] beat_q[$], exp_beat_q[$];
  logic [ADDR_W-1:0]   rd_q[$], exp_rd_q[$], stall_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] make_word(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    int k;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      k = int'(a) * 16 + i;
      w[i*16 +: 16] = (k < TAB_N) ? tab[k] : 16'hdead;
    end
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] garbage();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic fill_tab();
    int v;
    v = $urandom_range(0, 60);
    for (int i = 0; i < TAB_N; i++) begin
      if ($urandom_range(0, 11) == 0) v = v - $urandom_range(1, 3);
      else                            v = v + $urandom_range(0, 3);
      tab[i] = {5'($urandom), 11'(v)};
    end
  endtask

  task automatic set_ptr(input int idx, input int val);
    tab[idx] = {5'($urandom), 11'(val)};
  endtask

  // One clock: the SRAM answers a read seen last cycle, ready is chosen, outputs are sampled.
  task automatic step();
    @(negedge clock);
    cyc++;
    ptr_rd_data = pend_v ? make_word(pend_a) : garbage();
    pend_v = ptr_rd_en;
    pend_a = ptr_rd_addr;
    if (ptr_rd_en) begin
      rd_q.push_back(ptr_rd_addr);
      if (first_rd < 0) first_rd = cyc;
    end
    case (rdy_mode)
      1:       y_ready = 1'($urandom_range(0, 1));
      2:       y_ready = !(cyc == 4 || cyc == 5);
      default: y_ready = 1'b1;
    endcase
    if (y_valid && first_valid < 0) first_valid = cyc;
    if (y_valid && !y_ready) stall_q.push_back(y_addr);
    if (y_valid && y_ready) beat_q.push_back({y_empty, y_last, y_row, y_addr});
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic build_model(input int s, input int e);
    int buf_w;
    logic [ADDR_W-1:0] lo, hi;
    exp_beat_q.delete();
    exp_rd_q.delete();
    exp_err = 1'b0;
    buf_w = -1;
    for (int r = s; r <= e; r++) begin
      if (r / 16 != buf_w) begin
        exp_rd_q.push_back(ADDR_W'(r / 16));
        buf_w = r / 16;
      end
      if (r % 16 == 15) begin
        exp_rd_q.push_back(ADDR_W'(r / 16 + 1));
        buf_w = r / 16 + 1;
      end
      lo = tab[r][ADDR_W-1:0];
      hi = tab[r+1][ADDR_W-1:0];
      if (hi > lo) begin
        for (int a = int'(lo); a < int'(hi); a++)
          exp_beat_q.push_back({1'b0, (a == int'(hi) - 1), ADDR_W'(r), ADDR_W'(a)});
      end else begin
        if (hi < lo) exp_err = 1'b1;
`ifdef YSEQ_EMPTY_ROW_MARK_EN
        exp_beat_q.push_back({1'b1, 1'b1, ADDR_W'(r), lo});
`endif
      end
    end
  endtask

  task automatic run_range(input string tag, input int s, input int e, input int mode);
    build_model(s, e);
    beat_q.delete();
    rd_q.delete();
    stall_q.delete();
    done_cnt = 0; first_rd = -1; first_valid = -1; done_cyc = -1;
    rdy_mode = mode;
    cyc = 0;
    start_row = ADDR_W'(s);
    end_row   = ADDR_W'(e);
    start = 1'b1;
    step();
    start = 1'b0;
    while (done_cnt == 0 && cyc < BUDGET) step();
    repeat (3) step();
    check({tag, "/done_once"}, done_cnt, 1);
    check({tag, "/busy_end"}, busy, 0);
    check({tag, "/err"}, err, exp_err);
    check({tag, "/n_beats"}, beat_q.size(), exp_beat_q.size());
    for (int i = 0; i < beat_q.size() && i < exp_beat_q.size(); i++)
      check($sformatf("%s/beat%0d", tag, i), beat_q[i], exp_beat_q[i]);
    check({tag, "/n_reads"}, rd_q.size(), exp_rd_q.size());
    for (int i = 0; i < rd_q.size() && i < exp_rd_q.size(); i++)
      check($sformatf("%s/rd%0d", tag, i), rd_q[i], exp_rd_q[i]);
    $display("[TB] %s rows %0d..%0d: %0d beats, %0d reads", tag, s, e, beat_q.size(), rd_q.size());
  endtask

  initial begin
    int s, e;
    reset = 1'b0; start = 1'b0; start_row = '0; end_row = '0; y_ready = 1'b0;
    ptr_rd_data = '0; pend_v = 1'b0; pend_a = '0; rdy_mode = 0; cyc = 0;
    done_cnt = 0; first_rd = -1; first_valid = -1; done_cyc = -1;
    fill_tab();
    repeat (3) step();
    check("rst/busy", busy, 0);
    check("rst/done", done, 0);
    check("rst/err", err, 0);
    check("rst/ptr_rd_en", ptr_rd_en, 0);
    check("rst/ptr_rd_addr", ptr_rd_addr, 0);
    check("rst/y_valid", y_valid, 0);
    check("rst/y_addr", y_addr, 0);
    check("rst/y_row", y_row, 0);
    check("rst/y_last", y_last, 0);
    check("rst/y_empty", y_empty, 0);

    // Start asserted while reset is held: reset wins.
    start_row = 0; end_row = 3; start = 1'b1;
    step();
    check("start_in_reset/busy", busy, 0);
    start = 1'b0; reset = 1'b1;
    step();
    check("start_in_reset/busy2", busy, 0);
    check("start_in_reset/ptr_rd_en", ptr_rd_en, 0);

    fill_tab(); set_ptr(0, 5); set_ptr(1, 8); set_ptr(2, 8);
    run_range("t1_rows01", 0, 1, 0);
    check("t1/first_rd_cyc", first_rd, 1);
    check("t1/first_valid_cyc", first_valid, 3);

    fill_tab(); set_ptr(15, 20); set_ptr(16, 22);
    run_range("t2_row15", 15, 15, 0);
    check("t2/first_valid_cyc", first_valid, 5);

    fill_tab(); set_ptr(3, 10); set_ptr(4, 13);
    run_range("t3_backpressure", 3, 3, 2);
    check("t3/n_stall", stall_q.size(), 2);
    for (int i = 0; i < stall_q.size(); i++) check($sformatf("t3/stall_addr%0d", i), stall_q[i], 11);

    fill_tab(); set_ptr(4, 9); set_ptr(5, 7);
    run_range("t4_inverted", 4, 4, 0);
    check("t4/err_set", err, 1);

    run_range("t5_empty_range", 5, 2, 0);
    check("t5/done_cyc", done_cyc, 2);

    // Reset in the middle of a long row, then restart.
    fill_tab(); set_ptr(0, 100); set_ptr(1, 140);
    rdy_mode = 0; start_row = 0; end_row = 0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    check("t6/mid_valid", y_valid, 1);
    reset = 1'b0;
    step();
    check("t6/rst_y_valid", y_valid, 0);
    check("t6/rst_busy", busy, 0);
    check("t6/rst_ptr_rd_en", ptr_rd_en, 0);
    check("t6/rst_y_addr", y_addr, 0);
    check("t6/rst_y_last", y_last, 0);
    check("t6/rst_done", done, 0);
    reset = 1'b1;
    step();
    run_range("t6_restart", 0, 0, 0);

    for (int it = 0; it < 16; it++) begin
      fill_tab();
      s = $urandom_range(0, 80);
      e = s - 2 + $urandom_range(0, 22);
      if (e < 0) e = 0;
      run_range($sformatf("rnd%0d", it), s, e, 1);
    end

    fill_tab();
    run_range("top_of_space", 2040, 2047, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
